// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: one add/subtract/no-op plus arithmetic
// shift per clock, WIDTH steps, then a registered 2*WIDTH-bit signed product.

module xorn #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic         inv,
    output logic [N-1:0] y
);
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bit
            assign y[gi] = a[gi] ^ inv;
        end
    endgenerate
endmodule

module booth_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_reg, state_next;
    logic [WIDTH:0]      a_reg, a_next;
    logic [WIDTH-1:0]    q_reg, q_next;
    logic                qm1_reg, qm1_next;
    logic [WIDTH:0]      m_reg, m_next;
    logic [CW-1:0]       count_reg, count_next;
    logic [2*WIDTH-1:0]  product_reg, product_next;

    logic                add_sel, sub_sel;
    logic [WIDTH:0]      m_inv, b_operand, sum;
    logic [WIDTH:0]      a_shift;
    logic [WIDTH-1:0]    q_shift;

    // {Q[0], q_m1} = 01 adds M, 10 subtracts M; one adder serves both
    assign add_sel = ~q_reg[0] & qm1_reg;
    assign sub_sel = q_reg[0] & ~qm1_reg;

    xorn #(.N(WIDTH + 1)) u_inv (
        .a   (m_reg),
        .inv (sub_sel),
        .y   (m_inv)
    );

    assign b_operand = (add_sel | sub_sel) ? m_inv : '0;
    assign sum       = a_reg + b_operand + {{WIDTH{1'b0}}, sub_sel};

    // Arithmetic right shift of {A', Q, q_m1}
    assign a_shift = {sum[WIDTH], sum[WIDTH:1]};
    assign q_shift = {sum[0], q_reg[WIDTH-1:1]};

    always_comb begin
        state_next   = state_reg;
        a_next       = a_reg;
        q_next       = q_reg;
        qm1_next     = qm1_reg;
        m_next       = m_reg;
        count_next   = count_reg;
        product_next = product_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next     = '0;
                    q_next     = multiplier;
                    qm1_next   = 1'b0;
                    m_next     = {multiplicand[WIDTH-1], multiplicand};
                    count_next = CW'(WIDTH);
                    state_next = CALC;
                end
            end
            CALC: begin
                a_next     = a_shift;
                q_next     = q_shift;
                qm1_next   = q_reg[0];
                count_next = count_reg - CW'(1);
                if (count_reg == CW'(1)) begin
                    product_next = {a_shift[WIDTH-1:0], q_shift};
                    state_next   = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            q_reg       <= '0;
            qm1_reg     <= 1'b0;
            m_reg       <= '0;
            count_reg   <= '0;
            product_reg <= '0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            q_reg       <= q_next;
            qm1_reg     <= qm1_next;
            m_reg       <= m_next;
            count_reg   <= count_next;
            product_reg <= product_next;
        end
    end

    assign ready   = (state_reg == IDLE);
    assign done    = (state_reg == DONE);
    assign product = product_reg;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed and random checks of booth_seq_mult at WIDTH=8 and WIDTH=16:
// products, latency, handshake spacing, product hold and mid-operation reset.

module tb_booth_seq_mult;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0;
    logic [7:0]  mcand8 = '0, mplier8 = '0;
    logic        ready8, done8;
    logic [15:0] prod8;

    logic        start16 = 1'b0;
    logic [15:0] mcand16 = '0, mplier16 = '0;
    logic        ready16, done16;
    logic [31:0] prod16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    booth_seq_mult #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start8),
        .multiplicand (mcand8),
        .multiplier   (mplier8),
        .ready        (ready8),
        .done         (done8),
        .product      (prod8)
    );

    booth_seq_mult #(.WIDTH(16)) dut16 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start16),
        .multiplicand (mcand16),
        .multiplier   (mplier16),
        .ready        (ready16),
        .done         (done16),
        .product      (prod16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Called with dut8 idle and at posedge+1; returns at posedge+1 with dut8 idle
    task automatic run8(input logic [7:0] m, input logic [7:0] q,
                        input logic [15:0] exp, input string tag, input bit detail);
        int k;
        mcand8 = m; mplier8 = q; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        if (detail) check({tag, "_busy"}, 32'(ready8), 32'd0);
        k = 0;
        while (!done8 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_lat"}, k, 8);
        check({tag, "_prod"}, 32'(prod8), 32'(exp));
        @(posedge clk); #1;
        if (detail) begin
            check({tag, "_done_fall"}, 32'(done8), 32'd0);
            check({tag, "_ready_back"}, 32'(ready8), 32'd1);
        end
        $display("w8  %s: %0h * %0h -> %0h (want %0h) latency %0d", tag, m, q, prod8, exp, k);
    endtask

    task automatic run16(input logic [15:0] m, input logic [15:0] q, input logic [31:0] exp);
        int k;
        mcand16 = m; mplier16 = q; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        k = 0;
        while (!done16 && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        check("w16_lat", k, 16);
        check("w16_prod", prod16, exp);
        @(posedge clk); #1;
    endtask

    logic [7:0]  vm [7] = '{8'h03, 8'hFD, 8'h07, 8'h80, 8'h00, 8'h80, 8'h7F};
    logic [7:0]  vq [7] = '{8'h05, 8'h05, 8'hFA, 8'h80, 8'hFF, 8'h7F, 8'h7F};
    logic [15:0] ve [7] = '{16'h000F, 16'hFFF1, 16'hFFD6, 16'h4000, 16'h0000, 16'hC080, 16'h3F01};

    initial begin
        logic [15:0] held, pend;
        int last_acc, e, k;
        bit acc, saw_done;
        logic [7:0]  rm, rq;
        logic [15:0] wm, wq;

        // Reset state
        #3;
        check("rst_ready", 32'(ready8), 32'd1);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_prod", 32'(prod8), 32'd0);
        check("rst_ready16", 32'(ready16), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run8(vm[i], vq[i], ve[i], $sformatf("dir%0d", i), 1'b1);
        held = 16'h3F01;

        // start held high, fresh operands each cycle
        start8 = 1'b1;
        last_acc = -100;
        pend = '0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            acc = (cyc - last_acc) >= 10;
            rm = 8'($urandom); rq = 8'($urandom);
            mcand8 = rm; mplier8 = rq;
            check("hs_ready", 32'(ready8), 32'(acc));
            if (acc) begin
                e = $signed(rm) * $signed(rq);
                pend = e[15:0];
                last_acc = cyc;
                $display("hs  accept at edge %0d: %0h * %0h", cyc, rm, rq);
            end
            @(posedge clk); #1;
            if (cyc - last_acc == 8) begin
                check("hs_done", 32'(done8), 32'd1);
                check("hs_prod", 32'(prod8), 32'(pend));
                held = pend;
            end else begin
                check("hs_nodone", 32'(done8), 32'd0);
                check("hs_hold", 32'(prod8), 32'(held));
            end
        end
        start8 = 1'b0;
        @(posedge clk); #1;

        // Reset four cycles into CALC
        mcand8 = 8'h03; mplier8 = 8'h05; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(ready8), 32'd1);
        check("midrst_done", 32'(done8), 32'd0);
        check("midrst_prod", 32'(prod8), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8) saw_done = 1'b1;
        end
        check("midrst_no_done", 32'(saw_done), 32'd0);
        $display("rst aborted operation, done seen=%0d", saw_done);
        run8(8'h03, 8'h05, 16'h000F, "rst_fresh", 1'b1);

        // Random regression
        for (int i = 0; i < 1000; i++) begin
            rm = 8'($urandom); rq = 8'($urandom);
            e = $signed(rm) * $signed(rq);
            run8(rm, rq, e[15:0], "rnd8", 1'b0);
        end
        for (int i = 0; i < 1000; i++) begin
            wm = 16'($urandom); wq = 16'($urandom);
            if (i == 0) begin wm = 16'h8000; wq = 16'h8000; end
            e = $signed(wm) * $signed(wq);
            run16(wm, wq, e);
            $display("w16 %0h * %0h -> %0h (want %0h)", wm, wq, prod16, e);
        end

        k = total;
        $display("test done: total=%0d bad=%0d", k, bad);
        $finish;
    end
endmodule
